// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO and an RS485 driver-enable output.
// Latency: a word pushed into an empty FIFO while idle shows its start bit two clk edges after acceptance.
// Backpressure: wr_ready (registered "not full") drops when the FIFO fills; writes while it is low are ignored.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TURNAROUND = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] datain,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 tx,
  output logic                 de,
  output logic                 busy
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0] BIT_LAST  = 8'(OVERSAMPLE - 1);
  localparam logic [7:0] HOLD_LAST = 8'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_HOLD
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]          w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic                 r_wr_ready, r_tx, r_de, r_busy;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [7:0]           r_cnt;
  logic [3:0]           r_idx;
  logic                 w_push, w_pop, w_empty, w_full_nxt;
  logic                 w_bit_end, w_bit_state, w_tx;
  logic [DATA_BITS-1:0] w_head;

  // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign w_push       = wr_valid & r_wr_ready;
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_full_nxt   = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign w_bit_end    = (r_cnt == BIT_LAST);
  assign w_bit_state  = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PAR)   || (r_state == S_STOP);

  assign wr_ready = r_wr_ready;
  assign tx       = r_tx;
  assign de       = r_de;
  assign busy     = r_busy;

  // FIFO storage: contents need no reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= datain;
  end

  // FIFO pointers and registered not-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_ready <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ready <= ~w_full_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, FIFO pop and the line level for the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end && r_idx == DATA_LAST) w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        w_tx = r_par;
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end && r_idx == STOP_LAST) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else if (TURNAROUND == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timing, bit index, shift register and parity of the popped word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_state_nxt != r_state || (w_bit_state && w_bit_end))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 8'd1;

      if (w_state_nxt != r_state)
        r_idx <= '0;
      else if (w_bit_end && (r_state == S_DATA || r_state == S_STOP))
        r_idx <= r_idx + 4'd1;

      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= (^w_head) ^ (PARITY == 2);
      end else if (r_state == S_DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  // Registered outputs, each one cycle behind the state that produces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx   <= 1'b1;
      r_de   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx;
      r_de   <= (r_state != S_IDLE);
      r_busy <= ((r_state != S_IDLE) && (r_state != S_HOLD)) || !w_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: scoreboard-checked frames plus directed timing checks.
// Latency: checks the two-edge accept-to-start delay and the 16-cycle turnaround.
// Backpressure: fills the FIFO while the line is busy and checks wr_ready and dropped writes.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_datain, e_datain, o_datain;
  logic       d_wr_valid, e_wr_valid, o_wr_valid;
  logic       d_wr_ready, e_wr_ready, o_wr_ready;
  logic       d_tx, e_tx, o_tx;
  logic       d_de, e_de, o_de;
  logic       d_busy, e_busy, o_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int frames = 0;

  logic [7:0] exp_q[$];
  int         starts[$];

  logic [7:0] mon_w, mon_exp;
  logic       mon_sb, mon_pb, mon_abort;

  uart_tx_fifo u_dut (
    .clk(clk), .rst_n(rst_n), .datain(d_datain), .wr_valid(d_wr_valid),
    .wr_ready(d_wr_ready), .tx(d_tx), .de(d_de), .busy(d_busy)
  );

  uart_tx_fifo #(.PARITY(1)) u_even (
    .clk(clk), .rst_n(rst_n), .datain(e_datain), .wr_valid(e_wr_valid),
    .wr_ready(e_wr_ready), .tx(e_tx), .de(e_de), .busy(e_busy)
  );

  uart_tx_fifo #(.PARITY(2)) u_odd (
    .clk(clk), .rst_n(rst_n), .datain(o_datain), .wr_valid(o_wr_valid),
    .wr_ready(o_wr_ready), .tx(o_tx), .de(o_de), .busy(o_busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line level j cycles into a frame with 16x oversampling.
  function automatic logic exp_bit(input logic [7:0] d, input logic par_en,
                                   input logic par, input int j);
    int b;
    b = j / 16;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par_en && b == 9) return par;
    return 1'b1;
  endfunction

  // Called at a negedge; presents one word for one edge and records it if it should be taken.
  task automatic push_d(input logic [7:0] d, input logic acc);
    d_datain   = d;
    d_wr_valid = 1'b1;
    chk("wr_ready_at_push", {31'd0, d_wr_ready}, {31'd0, acc});
    @(posedge clk);
    if (acc) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_drain(input int bound);
    for (int t = 0; t < bound && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    for (int t = 0; t < 100 && d_de !== 1'b0; t++) @(negedge clk);
    chk("de_idle_after_drain", {31'd0, d_de}, 0);
  endtask

  task automatic wait_start_d(input string name);
    for (int t = 0; t < 40 && d_tx !== 1'b0; t++) @(negedge clk);
    chk(name, {31'd0, d_tx}, 0);
  endtask

  task automatic mon_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) mon_abort = 1'b1;
    end
  endtask

  // Receiver for the default instance: samples mid-bit and compares with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && d_tx === 1'b0) begin
        mon_abort = 1'b0;
        starts.push_back(cyc);
        mon_wait(8);
        mon_sb = d_tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(16);
          mon_w[i] = d_tx;
        end
        mon_wait(16);
        mon_pb = d_tx;
        if (!mon_abort) begin
          frames++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rx_unexpected_frame: got %02h, expected no frame", mon_w);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_w !== mon_exp || mon_sb !== 1'b0 || mon_pb !== 1'b1) begin
              fails++;
              $display("FAIL rx_frame: got data %02h start %b stop %b, expected data %02h start 0 stop 1",
                       mon_w, mon_sb, mon_pb, mon_exp);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, mism, mism_o, dh, len, drops, bdrops, f0;
    rst_n = 1'b0;
    d_datain = '0; e_datain = '0; o_datain = '0;
    d_wr_valid = 1'b0; e_wr_valid = 1'b0; o_wr_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx", {31'd0, d_tx}, 1);
    chk("rst_de", {31'd0, d_de}, 0);
    chk("rst_busy", {31'd0, d_busy}, 0);
    chk("rst_wr_ready", {31'd0, d_wr_ready}, 0);
    rst_n = 1'b1;
    chk("wr_ready_before_first_edge", {31'd0, d_wr_ready}, 0);
    @(negedge clk);
    chk("wr_ready_after_first_edge", {31'd0, d_wr_ready}, 1);
    repeat (2) @(negedge clk);

    // Single 0x55 frame: latency, waveform and turnaround
    push_d(8'h55, 1'b1);
    d_wr_valid = 1'b0;
    k = cyc;
    @(negedge clk);
    chk("t1_tx_at_k+1", {31'd0, d_tx}, 1);
    chk("t1_de_at_k+1", {31'd0, d_de}, 0);
    @(negedge clk);
    chk("t1_cycle_is_k+2", cyc - k, 2);
    chk("t1_tx_at_k+2", {31'd0, d_tx}, 0);
    chk("t1_de_at_k+2", {31'd0, d_de}, 1);
    mism = 0;
    dh = 0;
    while (d_de === 1'b1 && dh < 400) begin
      if (dh < 160 && d_tx !== exp_bit(8'h55, 1'b0, 1'b0, dh)) mism++;
      dh++;
      @(negedge clk);
    end
    chk("t1_waveform_mismatches", mism, 0);
    chk("t1_de_high_cycles", dh, 176);
    wait_drain(400);

    // Even and odd parity on 0x07
    e_datain = 8'h07; o_datain = 8'h07;
    e_wr_valid = 1'b1; o_wr_valid = 1'b1;
    chk("par_even_wr_ready", {31'd0, e_wr_ready}, 1);
    chk("par_odd_wr_ready", {31'd0, o_wr_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    e_wr_valid = 1'b0; o_wr_valid = 1'b0;
    for (int t = 0; t < 40 && e_tx !== 1'b0; t++) @(negedge clk);
    chk("par_start_seen", {31'd0, e_tx}, 0);
    mism = 0; mism_o = 0; len = 0;
    while (e_busy === 1'b1 && len < 400) begin
      if (len < 176) begin
        if (e_tx !== exp_bit(8'h07, 1'b1, 1'b1, len)) mism++;
        if (o_tx !== exp_bit(8'h07, 1'b1, 1'b0, len)) mism_o++;
      end
      if (len == 152) begin
        chk("par_even_bit", {31'd0, e_tx}, 1);
        chk("par_odd_bit", {31'd0, o_tx}, 0);
      end
      len++;
      @(negedge clk);
    end
    chk("par_frame_length", len, 176);
    chk("par_even_waveform_mismatches", mism, 0);
    chk("par_odd_waveform_mismatches", mism_o, 0);
    for (int t = 0; t < 60 && (e_de !== 1'b0 || o_de !== 1'b0); t++) @(negedge clk);
    chk("par_de_idle", {30'd0, e_de, o_de}, 0);

    // Back-to-back frames
    starts.delete();
    push_d(8'hA1, 1'b1);
    push_d(8'hB2, 1'b1);
    push_d(8'hC3, 1'b1);
    d_wr_valid = 1'b0;
    wait_start_d("b2b_start_seen");
    drops = 0; bdrops = 0;
    for (int j = 0; j < 480; j++) begin
      if (d_de !== 1'b1) drops++;
      if (d_busy !== 1'b1) bdrops++;
      @(negedge clk);
    end
    chk("b2b_de_drops", drops, 0);
    chk("b2b_busy_drops", bdrops, 0);
    wait_drain(200);
    chk("b2b_busy_low_at_end", {31'd0, d_busy}, 0);
    chk("b2b_frame_count", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("b2b_gap_1_2", starts[1] - starts[0], 160);
      chk("b2b_gap_2_3", starts[2] - starts[1], 160);
    end

    // FIFO fill with the line busy
    f0 = frames;
    for (int i = 0; i < 8; i++) push_d(8'h10 + 8'(i), (i < 5) ? 1'b1 : 1'b0);
    d_wr_valid = 1'b0;
    wait_drain(1400);
    chk("fill_frames_sent", frames - f0, 5);
    chk("fill_wr_ready_recovered", {31'd0, d_wr_ready}, 1);

    // Push in the middle of HOLD
    push_d(8'h81, 1'b1);
    d_wr_valid = 1'b0;
    wait_start_d("hold_first_start");
    drops = 0;
    for (int t = 0; t < 300 && d_busy === 1'b1; t++) begin
      if (d_de !== 1'b1) drops++;
      @(negedge clk);
    end
    chk("hold_entered", {31'd0, d_busy}, 0);
    for (int t = 0; t < 6; t++) begin
      if (d_de !== 1'b1) drops++;
      @(negedge clk);
    end
    push_d(8'h3C, 1'b1);
    d_wr_valid = 1'b0;
    if (d_de !== 1'b1) drops++;
    @(negedge clk);
    chk("hold_tx_at_k+1", {31'd0, d_tx}, 1);
    if (d_de !== 1'b1) drops++;
    @(negedge clk);
    chk("hold_tx_at_k+2", {31'd0, d_tx}, 0);
    if (d_de !== 1'b1) drops++;
    chk("hold_de_drops", drops, 0);
    wait_drain(400);

    // Reset during data bit 3 with words queued
    push_d(8'h5A, 1'b1);
    d_wr_valid = 1'b0;
    wait_start_d("rst_frame_start");
    push_d(8'h66, 1'b1);
    push_d(8'h77, 1'b1);
    d_wr_valid = 1'b0;
    repeat (70) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, d_tx}, 1);
    chk("midrst_de", {31'd0, d_de}, 0);
    chk("midrst_busy", {31'd0, d_busy}, 0);
    chk("midrst_wr_ready", {31'd0, d_wr_ready}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_wr_ready_after_release", {31'd0, d_wr_ready}, 1);
    chk("midrst_fifo_empty_busy", {31'd0, d_busy}, 0);
    drops = 0;
    for (int t = 0; t < 300; t++) begin
      if (d_tx !== 1'b1 || d_de !== 1'b0 || d_busy !== 1'b0) drops++;
      @(negedge clk);
    end
    chk("midrst_line_idle", drops, 0);
    push_d(8'h99, 1'b1);
    d_wr_valid = 1'b0;
    wait_drain(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL provide parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-002 The block SHALL provide parameter OVERSAMPLE, default 16, meaning clk cycles per bit (legal range 4..255).
REQ-003 The block SHALL provide parameter PARITY, default 0, meaning parity mode: 0 none, 1 even, 2 odd.
REQ-004 The block SHALL provide parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-005 The block SHALL provide parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of 2, at least 2).
REQ-006 The block SHALL provide parameter TURNAROUND, default 16, meaning the number of clk cycles that de stays high after the last stop bit (0..255).
REQ-007 The block SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-008 The block SHALL provide port clk, input, 1 bit: the single clock, which runs at OVERSAMPLE x the baud rate.
REQ-009 The block SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-010 The block SHALL provide port datain, input, DATA_BITS wide: the word to send.
REQ-011 The block SHALL provide port wr_valid, input, 1 bit: datain is valid.
REQ-012 The block SHALL provide port wr_ready, output, 1 bit: the FIFO can accept a word.
REQ-013 The block SHALL provide port tx, output, 1 bit: the serial line (idle high).
REQ-014 The block SHALL provide port de, output, 1 bit: the RS485 driver enable.
REQ-015 The block SHALL provide port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.

Function
REQ-016 A word SHALL be accepted on a rising clk edge where wr_valid=1 and wr_ready=1; wr_valid while wr_ready=0 SHALL be ignored, with no FIFO change.
REQ-017 wr_ready SHALL equal "FIFO not full", registered; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PAR, STOP, HOLD; every bit state SHALL last exactly OVERSAMPLE cycles, timed by a bit counter.
REQ-019 IDLE: tx=1, de=0; if the FIFO is non-empty, the FSM SHALL pop the head into the shift register and enter START.
REQ-020 Latency: for a word accepted at edge k into an empty FIFO while in IDLE, tx=0 and de=1 SHALL first appear after edge k+2.
REQ-021 START SHALL drive tx=0, then go to DATA.
REQ-022 DATA SHALL send DATA_BITS bits LSB first, then go to PAR if PARITY!=0, otherwise to STOP.
REQ-023 The parity bit SHALL be XOR of the data bits for even parity and its complement for odd parity, computed from the popped word only.
REQ-024 STOP SHALL drive tx=1 for STOP_BITS x OVERSAMPLE cycles.
REQ-025 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and enter START on the next cycle with no idle gap, keeping de=1.
REQ-026 At the end of STOP with an empty FIFO, the FSM SHALL enter HOLD, or IDLE if TURNAROUND=0.
REQ-027 HOLD SHALL keep tx=1 and de=1 for TURNAROUND cycles, then enter IDLE with de=0.
REQ-028 If the FIFO becomes non-empty during HOLD, the FSM SHALL pop and enter START immediately, with de continuous.
REQ-029 de SHALL be 1 in every state except IDLE.
REQ-030 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS) x OVERSAMPLE cycles.
REQ-031 All outputs SHALL be registered and glitch-free.
REQ-032 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, using an extra pointer bit to tell full from empty.
REQ-033 busy SHALL be 1 when the FSM is not in IDLE/HOLD or the FIFO is non-empty.

Reset
REQ-034 While rst_n=0, asynchronously: tx=1, de=0, busy=0, wr_ready=0; FSM in IDLE; FIFO emptied; counters at 0.
REQ-035 wr_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-036 Reset mid-frame SHALL abort the frame and discard all queued words; no partial bit SHALL resume after release.

Verification
REQ-037 Test: defaults, push 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each 16 cycles; start edge 2 cycles after accept; de falls 16 cycles after the stop bit.
REQ-038 Test: PARITY=1, push 0x07 -> parity bit 1; PARITY=2, push 0x07 -> parity bit 0; frame length 176 cycles.
REQ-039 Test: push 0xA1, 0xB2, 0xC3 back-to-back -> three contiguous frames, no gap between stop and start, de high throughout, busy low only after HOLD.
REQ-040 Test: FIFO_DEPTH=4, hold wr_valid with tx stalled -> wr_ready drops after the FIFO fills, extra writes are dropped, and exactly the accepted words are sent in order.
REQ-041 Test: a push during HOLD, cycle 8 of 16 -> start bit on the next cycles, with de never deasserted.
REQ-042 Test: rst_n low during DATA bit 3 -> tx=1 and de=0 immediately, FIFO empty; after release, tx stays idle until a new push.
